// File: rtl/volume_ramp_ctrl.sv
// Per-channel hysteresis, user-to-code mapping and click-free one-step ramping; one code step per STEP_DIV ticks.
// Changed codes are sent one at a time to the register writer over req/ack, round-robin; wr_req holds until wr_ack.
module volume_ramp_ctrl #(
   parameter int NUM_CH   = 2,
   parameter int IN_W     = 10,
   parameter int OUT_W    = 7,
   parameter int VOL_MIN  = 48,
   parameter int VOL_MAX  = 127,
   parameter int HYST     = 4,
   parameter int STEP_DIV = 50000,
   parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    unmute,
   input  logic [NUM_CH*IN_W-1:0]  user_in,
   output logic                    wr_req,
   output logic [CH_W-1:0]         wr_ch,
   output logic [OUT_W-1:0]        wr_data,
   input  logic                    wr_ack,
   output logic [NUM_CH*OUT_W-1:0] vol_cur,
   output logic                    settled
);

   localparam int CNT_W = $clog2(STEP_DIV);
   localparam int PW    = IN_W + OUT_W;
   localparam int SPAN  = VOL_MAX - VOL_MIN + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);
   localparam logic [OUT_W-1:0] VMIN_V  = OUT_W'(VOL_MIN);
   localparam logic [IN_W-1:0]  HYST_V  = IN_W'(HYST);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REQ  = 1'b1;

   logic [IN_W-1:0]  uin      [NUM_CH];
   logic [IN_W-1:0]  diff     [NUM_CH];
   logic [IN_W-1:0]  last_acc [NUM_CH];
   logic [PW-1:0]    prod     [NUM_CH];
   logic [OUT_W-1:0] mapped   [NUM_CH];
   logic [OUT_W-1:0] tgt      [NUM_CH];
   logic [OUT_W-1:0] eff      [NUM_CH];
   logic [OUT_W-1:0] cur      [NUM_CH];
   logic [OUT_W-1:0] nxt      [NUM_CH];
   logic [CH_W-1:0]  rot      [NUM_CH];

   logic [NUM_CH-1:0] accept, chg, at, pending, clr;
   logic [CNT_W-1:0]  cnt;
   logic              tick;
   logic [0:0]        state;
   logic [CH_W-1:0]   rr, pick_ch, rr_nxt;
   logic [CH_W:0]     ch_inc;
   logic              pick_vld;

   assign tick = (cnt == CNT_MAX);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign uin[k]    = user_in[k*IN_W +: IN_W];
      assign diff[k]   = (uin[k] >= last_acc[k]) ? (uin[k] - last_acc[k]) : (last_acc[k] - uin[k]);
      assign accept[k] = (diff[k] >= HYST_V) || (uin[k] == '0) || (&uin[k]);
      assign prod[k]   = PW'(uin[k]) * PW'(SPAN);
      assign mapped[k] = (uin[k] == '0) ? '0 : VMIN_V + OUT_W'(prod[k] >> IN_W);
      assign eff[k]    = unmute ? tgt[k] : '0;
      // The gap 1..VOL_MIN-1 is jumped in both directions so it never reaches the codec.
      assign nxt[k]    = (cur[k] == eff[k])                  ? cur[k] :
                         (cur[k] == '0)                      ? VMIN_V :
                         ((cur[k] == VMIN_V) && (eff[k] == '0)) ? '0 :
                         (cur[k] < eff[k])                   ? cur[k] + OUT_W'(1) :
                                                               cur[k] - OUT_W'(1);
      assign chg[k]    = tick && (cur[k] != eff[k]);
      assign at[k]     = (cur[k] == eff[k]);
      assign vol_cur[k*OUT_W +: OUT_W] = cur[k];
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_rot
      logic [CH_W:0] s;
      assign s      = {1'b0, rr} + (CH_W+1)'(i);
      assign rot[i] = (s >= (CH_W+1)'(NUM_CH)) ? CH_W'(s - (CH_W+1)'(NUM_CH)) : s[CH_W-1:0];
   end

   // Scan from the far end so the candidate closest to rr is the one kept.
   always_comb begin
      pick_vld = 1'b0;
      pick_ch  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pending[rot[i]]) begin
            pick_vld = 1'b1;
            pick_ch  = rot[i];
         end
      end
   end

   always_comb begin
      clr = '0;
      if (state == S_IDLE && pick_vld) clr[pick_ch] = 1'b1;
   end

   assign ch_inc = {1'b0, wr_ch} + (CH_W+1)'(1);
   assign rr_nxt = (ch_inc >= (CH_W+1)'(NUM_CH)) ? '0 : ch_inc[CH_W-1:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_CH; k++) begin
            last_acc[k] <= '0;
            tgt[k]      <= '0;
            cur[k]      <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (accept[k]) begin
               last_acc[k] <= uin[k];
               tgt[k]      <= mapped[k];
            end
            if (chg[k]) cur[k] <= nxt[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt     <= '0;
         pending <= '0;
         state   <= S_IDLE;
         rr      <= '0;
         wr_req  <= 1'b0;
         wr_ch   <= '0;
         wr_data <= '0;
         settled <= 1'b1;
      end else begin
         cnt     <= tick ? '0 : cnt + CNT_W'(1);
         // A fresh ramp step on the channel being latched must survive the clear.
         pending <= (pending & ~clr) | chg;
         settled <= (&at) && (pending == '0) && (state == S_IDLE);
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  wr_req  <= 1'b1;
                  wr_ch   <= pick_ch;
                  wr_data <= cur[pick_ch];
                  state   <= S_REQ;
               end
            end
            default: begin
               if (wr_ack) begin
                  wr_req <= 1'b0;
                  rr     <= rr_nxt;
                  state  <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_volume_ramp_ctrl.sv
// Directed bench for volume_ramp_ctrl with NUM_CH=2, STEP_DIV=4 and a delay-programmable acknowledging writer.
module tb_volume_ramp_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        unmute = 1'b0;
   logic [19:0] user_in = '0;
   logic        wr_req;
   logic [0:0]  wr_ch;
   logic [6:0]  wr_data;
   logic        wr_ack = 1'b0;
   logic [13:0] vol_cur;
   logic        settled;

   int n_cmp = 0;
   int n_err = 0;
   int ack_dly = 0;
   int wait_cnt = 0;
   int stab_err = 0;
   int bad_code = 0;
   logic       prev_req = 1'b0;
   logic [0:0] prev_ch = '0;
   logic [6:0] prev_dat = '0;
   int wlog_ch[$];
   int wlog_dat[$];
   int last_dat[2];

   always #5 clk = ~clk;

   volume_ramp_ctrl #(
      .NUM_CH(2), .IN_W(10), .OUT_W(7), .VOL_MIN(48), .VOL_MAX(127),
      .HYST(4), .STEP_DIV(4), .CH_W(1)
   ) dut (
      .clk(clk), .rstn(rstn), .unmute(unmute), .user_in(user_in),
      .wr_req(wr_req), .wr_ch(wr_ch), .wr_data(wr_data), .wr_ack(wr_ack),
      .vol_cur(vol_cur), .settled(settled)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_settled(input int bound, output bit ok);
      ok = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < bound; i++) begin
         if (settled === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Register-writer model plus protocol monitors, all sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            wr_ack   = 1'b0;
            wait_cnt = 0;
            prev_req = 1'b0;
         end else begin
            if (prev_req && wr_req && (wr_ch !== prev_ch || wr_data !== prev_dat)) stab_err++;
            prev_req = wr_req;
            prev_ch  = wr_ch;
            prev_dat = wr_data;
            for (int c = 0; c < 2; c++)
               if (vol_cur[c*7 +: 7] > 7'd0 && vol_cur[c*7 +: 7] < 7'd48) bad_code++;
            if (wr_req && wr_data > 7'd0 && wr_data < 7'd48) bad_code++;
            if (wr_ack) begin
               wr_ack = 1'b0;
            end else if (wr_req) begin
               if (wait_cnt >= ack_dly) begin
                  wr_ack   = 1'b1;
                  wait_cnt = 0;
                  wlog_ch.push_back(int'(wr_ch));
                  wlog_dat.push_back(int'(wr_data));
                  last_dat[wr_ch] = int'(wr_data);
               end else begin
                  wait_cnt++;
               end
            end
         end
      end
   end

   initial begin
      bit ok;
      int cyc;
      int errs;

      // 1: reset state, then muted input has no effect
      user_in[9:0] = 10'd77;
      repeat (3) @(negedge clk);
      chk("rst_wr_req", wr_req, 0);
      chk("rst_wr_ch", wr_ch, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_vol_cur", vol_cur, 0);
      chk("rst_settled", settled, 1);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      chk("t1_vol_cur", vol_cur, 0);
      chk("t1_writes", wlog_ch.size(), 0);
      chk("t1_wr_req", wr_req, 0);
      chk("t1_settled", settled, 1);

      // 2: full-scale ramp on ch0
      unmute = 1'b1;
      user_in[9:0] = 10'd1023;
      cyc = 0;
      while (vol_cur[6:0] == 7'd0 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      chk("t2_first_step", vol_cur[6:0], 48);
      wait_settled(500, ok);
      chk("t2_settle_in_time", ok, 1);
      chk("t2_cur0", vol_cur[6:0], 127);
      chk("t2_cur1", vol_cur[13:7], 0);
      chk("t2_nwrites", wlog_ch.size(), 80);
      errs = 0;
      for (int i = 0; i < wlog_ch.size(); i++)
         if (wlog_ch[i] != 0 || wlog_dat[i] != 48 + i) errs++;
      chk("t2_write_seq", errs, 0);
      chk("t2_last_write", last_dat[0], 127);
      chk("t2_settled", settled, 1);

      // 3: hysteresis
      user_in[9:0] = 10'd512;
      wait_settled(400, ok);
      chk("t3_settle_512", ok, 1);
      chk("t3_cur0_88", vol_cur[6:0], 88);
      wlog_ch.delete();
      wlog_dat.delete();
      user_in[9:0] = 10'd514;
      repeat (40) @(negedge clk);
      chk("t3_small_delta_writes", wlog_ch.size(), 0);
      chk("t3_small_delta_cur", vol_cur[6:0], 88);
      user_in[9:0] = 10'd600;
      wait_settled(200, ok);
      chk("t3_settle_600", ok, 1);
      chk("t3_cur0_94", vol_cur[6:0], 94);
      chk("t3_nwrites", wlog_ch.size(), 6);
      chk("t3_last_write", last_dat[0], 94);

      // 4: both channels ramping, slow writer
      ack_dly = 10;
      wlog_ch.delete();
      wlog_dat.delete();
      user_in = {10'd1023, 10'd1023};
      wait_settled(2000, ok);
      chk("t4_settle", ok, 1);
      errs = 0;
      for (int i = 1; i < 8 && i < wlog_ch.size(); i++)
         if (wlog_ch[i] == wlog_ch[i-1]) errs++;
      chk("t4_min_writes", wlog_ch.size() >= 8, 1);
      chk("t4_alternation", errs, 0);
      chk("t4_cur0", vol_cur[6:0], 127);
      chk("t4_cur1", vol_cur[13:7], 127);
      chk("t4_last_ch0", last_dat[0], 127);
      chk("t4_last_ch1", last_dat[1], 127);
      chk("t4_stable_while_req", stab_err, 0);

      // 5: mute ramps to 48 then 0; unmute restores
      ack_dly = 0;
      unmute = 1'b0;
      cyc = 0;
      while (vol_cur[6:0] != 7'd0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      chk("t5_ramp_time", (cyc >= 317 && cyc <= 320), 1);
      wait_settled(200, ok);
      chk("t5_settle_mute", ok, 1);
      chk("t5_cur0", vol_cur[6:0], 0);
      chk("t5_cur1", vol_cur[13:7], 0);
      chk("t5_last_ch0", last_dat[0], 0);
      chk("t5_last_ch1", last_dat[1], 0);
      chk("t5_no_gap_codes", bad_code, 0);
      unmute = 1'b1;
      wait_settled(600, ok);
      chk("t5_settle_unmute", ok, 1);
      chk("t5_restore_cur0", vol_cur[6:0], 127);
      chk("t5_restore_cur1", vol_cur[13:7], 127);
      chk("t5_restore_last0", last_dat[0], 127);

      // 6: reset during a handshake
      ack_dly = 20;
      user_in[9:0] = 10'd0;
      cyc = 0;
      while (wr_req !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("t6_req_seen", wr_req, 1);
      repeat (3) @(negedge clk);
      chk("t6_req_held", wr_req, 1);
      rstn = 1'b0;
      #1;
      chk("t6_async_wr_req", wr_req, 0);
      chk("t6_async_vol_cur", vol_cur, 0);
      chk("t6_async_settled", settled, 1);
      @(negedge clk);
      ack_dly = 0;
      user_in[9:0] = 10'd1023;
      rstn = 1'b1;
      wait_settled(600, ok);
      chk("t6_settle_after_rst", ok, 1);
      chk("t6_cur0", vol_cur[6:0], 127);
      chk("t6_cur1", vol_cur[13:7], 127);
      chk("t6_last_ch0", last_dat[0], 127);
      chk("end_no_gap_codes", bad_code, 0);
      chk("end_stable_while_req", stab_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
